// File: rtl/stack_lifo.sv
// Parameterised LIFO stack with occupancy tracking, sticky overflow/underflow
// flags and an optional circular mode that overwrites the oldest entry.
module stack_lifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int WRAP  = 0,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam bit            WRAP_EN = (WRAP != 0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             r_udf;

  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_wp_inc;
  logic [PW-1:0] w_wp_dec;
  logic [PW-1:0] w_wp_dec2;
  logic          w_push_new;
  logic          w_replace;
  logic          w_pop_ok;
  logic          w_set_ovf;
  logic          w_set_udf;
  logic          w_we;
  logic [PW-1:0] w_waddr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Explicit compare-and-wrap: DEPTH need not be a power of two.
  assign w_wp_inc  = (r_wp == LAST)     ? '0   : r_wp + PW'(1);
  assign w_wp_dec  = (r_wp == '0)       ? LAST : r_wp - PW'(1);
  assign w_wp_dec2 = (w_wp_dec == '0)   ? LAST : w_wp_dec - PW'(1);

  // Push+pop on an empty stack degrades to a plain push; on a non-empty
  // stack it replaces the top without touching pointer or count.
  assign w_push_new = push & (~pop | w_empty) & (~w_full | WRAP_EN);
  assign w_replace  = push & pop & ~w_empty;
  assign w_pop_ok   = pop & ~push & ~w_empty;
  assign w_set_ovf  = push & ~pop & w_full & ~WRAP_EN;
  assign w_set_udf  = pop & ~push & w_empty;

  assign w_we    = w_push_new | w_replace;
  assign w_waddr = w_replace ? w_wp_dec : r_wp;

  // NOTE: storage carries no reset; validity is tracked by r_count alone,
  // which keeps the array a plain register file without reset fan-out.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= d;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_count <= '0;
      r_q     <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_push_new) begin
        r_wp <= w_wp_inc;
        if (!w_full) r_count <= r_count + CW'(1);
        r_q  <= d;
      end else if (w_replace) begin
        r_q <= d;
      end else if (w_pop_ok) begin
        r_wp    <= w_wp_dec;
        r_count <= r_count - CW'(1);
        r_q     <= (r_count == CW'(1)) ? '0 : r_mem[w_wp_dec2];
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
      r_udf <= w_set_udf | (r_udf & ~clr_err);
    end
  end

  assign q         = r_q;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_stack_lifo.sv
// Table-driven bench for stack_lifo: three configurations share stimulus,
// each vector names the instance it checks; expectations flow via a queue.
module tb_stack_lifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        clr_err = 1'b0;
  logic [11:0] d = '0;

  logic [11:0] q0, q1, q2;
  logic [2:0]  c0, c1, c2;
  logic        e0, e1, e2, f0, f1, f2, o0, o1, o2, u0, u1, u2;

  int total = 0;
  int bad   = 0;
  int cur_sel = 0;

  always #5 clk = ~clk;

  // sel 0: DEPTH=4 saturating, sel 1: DEPTH=4 circular, sel 2: DEPTH=5 circular
  stack_lifo #(.WIDTH(12), .DEPTH(4), .WRAP(0)) u_sat4 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
    .q(q0), .empty(e0), .full(f0), .count(c0), .overflow(o0), .underflow(u0));
  stack_lifo #(.WIDTH(12), .DEPTH(4), .WRAP(1)) u_wrap4 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
    .q(q1), .empty(e1), .full(f1), .count(c1), .overflow(o1), .underflow(u1));
  stack_lifo #(.WIDTH(12), .DEPTH(5), .WRAP(1)) u_wrap5 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
    .q(q2), .empty(e2), .full(f2), .count(c2), .overflow(o2), .underflow(u2));

  logic [11:0] s_q;
  logic [2:0]  s_c;
  logic        s_e, s_f, s_o, s_u;

  always_comb begin
    s_q = q0; s_c = c0; s_e = e0; s_f = f0; s_o = o0; s_u = u0;
    if (cur_sel == 1) begin
      s_q = q1; s_c = c1; s_e = e1; s_f = f1; s_o = o1; s_u = u1;
    end else if (cur_sel == 2) begin
      s_q = q2; s_c = c2; s_e = e2; s_f = f2; s_o = o2; s_u = u2;
    end
  end

  typedef struct {
    int          sel;
    bit          rst, push, pop, clr;
    logic [11:0] d;
    logic [11:0] q;
    logic [2:0]  cnt;
    bit          emp, ful, ovf, udf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(int sel, bit r, bit pu, bit po, bit cl, int dv,
                              int qv, int cv, bit em, bit fu, bit ov, bit ud);
    vec_t v;
    v.sel = sel; v.rst = r; v.push = pu; v.pop = po; v.clr = cl;
    v.d = 12'(dv); v.q = 12'(qv); v.cnt = 3'(cv);
    v.emp = em; v.ful = fu; v.ovf = ov; v.udf = ud;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input vec_t e);
    check({tag, ".q"},         32'(s_q), 32'(e.q));
    check({tag, ".count"},     32'(s_c), 32'(e.cnt));
    check({tag, ".empty"},     32'(s_e), 32'(e.emp));
    check({tag, ".full"},      32'(s_f), 32'(e.ful));
    check({tag, ".overflow"},  32'(s_o), 32'(e.ovf));
    check({tag, ".underflow"}, 32'(s_u), 32'(e.udf));
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t  e;
    string tag;
    tag = $sformatf("v%0d", idx);
    cur_sel = v.sel;
    @(negedge clk);
    if (v.rst) begin
      push = 1'b0; pop = 1'b0; clr_err = 1'b0; d = '0;
      rst = 1'b1;
      sb.push_back(v);
      #1;
      e = sb.pop_front();
      compare(tag, e);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      push = v.push; pop = v.pop; clr_err = v.clr; d = v.d;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare(tag, e);
    end
  endtask

  // Helpers for building the table.
  function automatic vec_t R(int sel);
    return mk(sel, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endfunction

  initial begin
    // 1. fill and drain, DEPTH=4
    vecs.push_back(R(0));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(0, 0, 1, 0, 0, k, k, k, 0, k == 4, 0, 0));
    for (int k = 3; k >= 0; k--) vecs.push_back(mk(0, 0, 0, 1, 0, 0, k, k, k == 0, 0, 0, 0));
    // 2. saturating overflow, then clear
    vecs.push_back(R(0));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(0, 0, 1, 0, 0, k, k, k, 0, k == 4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 9, 4, 4, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 3, 3, 0, 0, 0, 0));
    // 3. circular wrap, DEPTH=4
    vecs.push_back(R(1));
    for (int k = 1; k <= 6; k++)
      vecs.push_back(mk(1, 0, 1, 0, 0, k, k, (k > 4) ? 4 : k, 0, k >= 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 5, 3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 4, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    // 4. simultaneous push+pop
    vecs.push_back(R(0));
    for (int k = 1; k <= 3; k++) vecs.push_back(mk(0, 0, 1, 0, 0, k, k, k, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 7, 7, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 5, 5, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 6, 6, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 7, 7, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 9, 9, 4, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8, 8, 4, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 7, 3, 0, 0, 0, 0));
    // 5b. set-beats-clear for both error flags
    vecs.push_back(R(0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(0, 0, 1, 0, 0, k, k, k, 0, k == 4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 9, 4, 4, 0, 1, 1, 0));
    // 6. non-power-of-two depth, DEPTH=5 circular
    vecs.push_back(R(2));
    for (int k = 1; k <= 12; k++)
      vecs.push_back(mk(2, 0, 1, 0, 0, k, k, (k > 5) ? 5 : k, 0, k >= 5, 0, 0));
    for (int k = 11; k >= 8; k--)
      vecs.push_back(mk(2, 0, 0, 1, 0, 0, k, k - 7, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // 5a. asynchronous reset between edges while count=2
    apply(1000, R(0));
    apply(1001, mk(0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    apply(1002, mk(0, 0, 1, 0, 0, 2, 2, 2, 0, 0, 0, 0));
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    #2;
    rst = 1'b1;
    sb.push_back(R(0));
    #1;
    begin
      vec_t e;
      e = sb.pop_front();
      compare("midrst", e);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(1003, mk(0, 0, 1, 0, 0, 5, 5, 1, 0, 0, 0, 0));
    apply(1004, mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));

    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stack_lifo.md
# stack_lifo

Parameterised hardware LIFO stack built around the `stackram` storage style. It is generalised in width and depth. It adds push/pop control, occupancy tracking, full/empty status, sticky overflow/underflow errors, and an optional circular mode that overwrites the oldest entry. It serves as the return/operand stack for the vector generator sequencer and replaces hand-driven address sequencing of `stackram`.

## Interface
- `WIDTH`, 12: data word width in bits, ≥1.
- `DEPTH`, 4: number of entries, ≥2. Any integer value is allowed; it need not be a power of two.
- `WRAP`, 0: full-stack push behaviour.
  - 0 = saturating: the push is dropped and overflow is flagged.
  - 1 = circular: the push overwrites the oldest entry; no overflow is flagged.
- `CW` (derived, localparam): $clog2(DEPTH+1). This is the width of `count`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `push`  in  1  push `d` this cycle.
- `pop`  in  1  pop the top entry this cycle.
- `d`  in  WIDTH  data to push.
- `clr_err`  in  1  clear the sticky error flags.
- `q`  out  WIDTH  registered top-of-stack.
- `empty`  out  1  high when `count`==0.
- `full`  out  1  high when `count`==DEPTH.
- `count`  out  CW  number of valid entries, 0..DEPTH.
- `overflow`  out  1  sticky error: a push was dropped (WRAP=0 only).
- `underflow`  out  1  sticky error: a pop was attempted on an empty stack.

## Operation
Storage:
- Storage is a DEPTH×WIDTH register array with a write pointer `wp` in the range 0..DEPTH-1.
- The top entry lives at index `wp-1` mod DEPTH.
- The array itself is not reset.

Command decode, evaluated each rising edge from the current `count`:
- **Idle** (push=0, pop=0): no change.
- **Push, not full:**
  - mem[wp] ← d.
  - wp ← wp+1 mod DEPTH.
  - count+1.
  - q ← d.
- **Push, full, WRAP=0:**
  - All state unchanged.
  - overflow ← 1.
- **Push, full, WRAP=1:**
  - Write and pointer advance as for a normal push.
  - count stays DEPTH.
  - q ← d.
  - The oldest entry is lost.
- **Pop, count>1:**
  - wp ← wp-1 mod DEPTH.
  - count-1.
  - q ← mem[wp-2 mod DEPTH], the new top.
- **Pop, count==1:**
  - wp-1, count ← 0.
  - q ← 0.
- **Pop, empty:**
  - All state unchanged.
  - underflow ← 1.
- **Push+pop, count≥1:** replace the top.
  - mem[wp-1] ← d, q ← d.
  - wp and count unchanged.
  - No error is flagged, even when full.
- **Push+pop, empty:** treated as a plain push. No underflow is flagged.

Error flags:
- `clr_err` clears both sticky flags.
- If a new error occurs in the same cycle as `clr_err`, the set wins.

Circular-mode occupancy:
- In WRAP=1, `count` saturates at DEPTH.
- Popping after wrap-around returns the most recent DEPTH pushes in reverse order, then reports empty.

Arithmetic:
- All pointer arithmetic is modulo DEPTH, with explicit compare-and-wrap logic.
- For non-power-of-two DEPTH, natural binary overflow must not be relied on.
- `count` arithmetic is unsigned CW bits and never exceeds DEPTH.

## Timing
Reset, asserted asynchronously while `rst`=1:
- q=0, count=0, empty=1, full=0, overflow=0, underflow=0, wp=0.
- Reset asserted mid-operation discards all contents immediately.
- The first edge after `rst` deasserts processes commands normally.

Latency:
- One cycle for all commands: every output reflects the command sampled at edge k, from just after edge k.
- A value pushed at edge k appears on `q` after edge k.
- A pop at edge k exposes the new top on `q` after edge k.

Handshake and status outputs:
- There is no backpressure. The caller must observe `full`/`empty`.
- Illegal commands are absorbed and only flagged.
- `empty` and `full` are decoded from the registered `count` and are glitch-free.
- `q` holds its value between commands.
- `q` is 0 whenever `empty`=1.

## Test plan
1. **Reset, then fill.** Use DEPTH=4, WIDTH=12. Push 1,2,3,4 on consecutive edges.
   - Expect count 1→4 and q=1,2,3,4.
   - Expect full=1 after the 4th push.
   - Then pop four times: expect q=3,2,1,0, count 3→0, empty=1, no error flags.
2. **Saturating overflow.** WRAP=0, stack full with 1..4. Push 9.
   - Expect overflow=1 and q=4, count=4 unchanged.
   - Then pop: expect q=3.
   - Then assert clr_err: expect overflow=0.
3. **Circular wrap.** WRAP=1. Push 1..6.
   - Expect count=4 and q=6, overflow=0.
   - Then pop four times: expect q=5,4,3,0 and empty=1.
   - A fifth pop gives underflow=1.
4. **Simultaneous push+pop.**
   - With stack 1,2,3, push+pop d=7: expect q=7, count=3. Then pop: expect q=2.
   - When empty, push+pop d=5: expect q=5, count=1, underflow=0.
   - When full, push+pop d=8: expect overflow=0, count=4, q=8.
5. **Reset mid-operation and error-clear priority.**
   - Assert rst asynchronously between edges while count=2: expect all outputs at reset values immediately.
   - Pop on empty while clr_err=1: expect underflow=1.
6. **Non-power-of-two depth.** DEPTH=5, WRAP=1. Push 1..12, then pop five times.
   - Expect q=11,10,9,8,0.
   - Confirms modulo-5 pointer wrap.
